// File: rtl/wbmultipwm_pkg.sv
// wbmultipwm_pkg: register map and CTRL bit positions shared by the wbmultipwm slice
// Ports: none (package).
package wbmultipwm_pkg;
    localparam logic [1:0] ADDR_SAMPLE = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_RELOAD = 2'd2;
    localparam logic [1:0] ADDR_CHAN   = 2'd3;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_CLR    = 2;
    localparam int CTRL_AUXLD  = 16;
    localparam int CTRL_AUX    = 20;
endpackage

// File: rtl/wbmultipwm_if.sv
// wbmultipwm_if: pipelined Wishbone slave bus bundle for wbmultipwm
// Ports: none; signals i_wb_cyc/stb/we/addr/data driven by master, o_wb_ack/stall/data by slave.
interface wbmultipwm_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [1:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;
    modport master (output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
                    input  o_wb_ack, o_wb_stall, o_wb_data);
    modport slave  (input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
                    output o_wb_ack, o_wb_stall, o_wb_data);
endinterface

// File: rtl/wbmultipwm_pwmfifo.sv
// pwmfifo: synchronous frame FIFO with fill count; flush empties it and overrides any pop
// Ports: i_clk, i_reset (sync, active-high); i_push/i_data write; i_pop reads the head o_data
//        (valid while !o_empty); i_flush; o_full, o_empty, o_fill (0..2**LGDEPTH).
module pwmfifo #(
    parameter int WIDTH   = 32,
    parameter int LGDEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [WIDTH-1:0]   i_data,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [LGDEPTH:0]   o_fill
);
    logic [WIDTH-1:0]   mem_q [2**LGDEPTH];
    logic [LGDEPTH-1:0] wr_q, rd_q;
    logic [LGDEPTH:0]   fill_q;
    logic               wr, rd;

    assign o_full  = fill_q[LGDEPTH];
    assign o_empty = (fill_q == '0);
    assign o_fill  = fill_q;
    assign o_data  = mem_q[rd_q];
    // A push into a full FIFO is dropped even if a pop happens the same cycle.
    assign wr = i_push & ~o_full;
    assign rd = i_pop & ~o_empty;

    always_ff @(posedge i_clk)
        if (wr) mem_q[wr_q] <= i_data;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
        end else begin
            wr_q   <= wr_q + LGDEPTH'(wr);
            rd_q   <= rd_q + LGDEPTH'(rd);
            fill_q <= fill_q + (LGDEPTH+1)'(wr) - (LGDEPTH+1)'(rd);
        end
    end
endmodule

// File: rtl/wbmultipwm.sv
// wbmultipwm: multi-channel FIFO-buffered PWM audio controller on a pipelined Wishbone slave
// Ports: i_clk, i_reset (sync, active-high); wb (wbmultipwm_if.slave);
//        o_pwm[NCHAN] PWM outputs, o_aux[NAUX] aux controls, o_int FIFO-low interrupt.
// Define WBMULTIPWM_VARIABLE_RATE_EN to make the sample period R writable at addr 2.
module wbmultipwm
    import wbmultipwm_pkg::*;
#(
    parameter int NCHAN          = 2,
    parameter int SAMPLE_BITS    = 16,
    parameter int TIMING_BITS    = 16,
    parameter int LGFIFO         = 4,
    parameter int DEFAULT_RELOAD = 1814,
    parameter int NAUX           = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    wbmultipwm_if.slave      wb,
    output logic [NCHAN-1:0] o_pwm,
    output logic [NAUX-1:0]  o_aux,
    output logic             o_int
);
    localparam int SB = SAMPLE_BITS;
    localparam int TB = TIMING_BITS;
    localparam int FW = NCHAN * SB;

    logic              wr_stb, wr_sample, wr_ctrl, push, flush, tick;
    logic              fifo_full, fifo_empty;
    logic [LGFIFO:0]   fill;
    logic [FW-1:0]     push_data, stage_q, head;
    logic [2:0]        wr_chan_q;
    logic [TB-1:0]     reload, timer_q, count_q;
    logic [TB-1:0]     duty_q [NCHAN];
    logic [TB-1:0]     conv [NCHAN];
    logic signed [TB:0] half;
    logic              enable_q, under_q, over_q, int_q, ack_q;
    logic [NAUX-1:0]   aux_q;
    logic [31:0]       rdata_d, rdata_q, ctrl_rd;
    logic              unused_ok;

    assign wr_stb    = wb.i_wb_stb & wb.i_wb_we;
    assign wr_sample = wr_stb & (wb.i_wb_addr == ADDR_SAMPLE);
    assign wr_ctrl   = wr_stb & (wb.i_wb_addr == ADDR_CTRL);
    assign flush     = wr_ctrl & wb.i_wb_data[CTRL_FLUSH];
    assign push      = wr_sample & (wr_chan_q == 3'(NCHAN - 1));
    assign tick      = enable_q & (timer_q == '0);

    // The last channel's sample goes straight from the bus into the pushed frame.
    always_comb begin
        push_data = stage_q;
        push_data[FW-1 -: SB] = wb.i_wb_data[SB-1:0];
    end

    always_ff @(posedge i_clk)
        for (int c = 0; c < NCHAN; c++)
            if (wr_sample && wr_chan_q == 3'(c)) stage_q[c*SB +: SB] <= wb.i_wb_data[SB-1:0];

    pwmfifo #(.WIDTH(FW), .LGDEPTH(LGFIFO)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_pop   (tick),
        .i_flush (flush),
        .i_data  (push_data),
        .o_data  (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_fill  (fill)
    );

`ifdef WBMULTIPWM_VARIABLE_RATE_EN
    logic [TB-1:0] reload_q;
    always_ff @(posedge i_clk)
        if (i_reset) reload_q <= TB'(DEFAULT_RELOAD);
        else if (wr_stb && wb.i_wb_addr == ADDR_RELOAD)
            reload_q <= (wb.i_wb_data[TB-1:0] < TB'(2)) ? TB'(2) : wb.i_wb_data[TB-1:0];
    assign reload = reload_q;
`else
    assign reload = TB'(DEFAULT_RELOAD);
`endif

    // Duty = sample centred on R/2, clamped to the full period [0, R].
    assign half = $signed({1'b0, reload >> 1});
    for (genvar c = 0; c < NCHAN; c++) begin : g_conv
        logic signed [TB:0] sum;
        assign sum     = (TB+1)'($signed(head[c*SB +: SB])) + half;
        assign conv[c] = sum[TB] ? '0 : (sum[TB-1:0] > reload) ? reload : sum[TB-1:0];
    end

    // Timer reloads from the current R only at a tick, so an R change never cuts a period short.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            timer_q <= TB'(DEFAULT_RELOAD - 1);
            count_q <= '0;
            o_pwm   <= '0;
            for (int c = 0; c < NCHAN; c++) duty_q[c] <= TB'(DEFAULT_RELOAD >> 1);
        end else begin
            timer_q <= (!enable_q || tick) ? reload - TB'(1) : timer_q - TB'(1);
            count_q <= (!enable_q || tick) ? '0 : count_q + TB'(1);
            for (int c = 0; c < NCHAN; c++) begin
                if (tick && !fifo_empty) duty_q[c] <= conv[c];
                o_pwm[c] <= enable_q && (duty_q[c] > count_q);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_chan_q <= '0;
            enable_q  <= 1'b0;
            under_q   <= 1'b0;
            over_q    <= 1'b0;
            aux_q     <= '0;
            int_q     <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (flush || push) wr_chan_q <= '0;
            else if (wr_sample) wr_chan_q <= wr_chan_q + 3'd1;
            if (wr_ctrl) begin
                enable_q <= wb.i_wb_data[CTRL_EN];
                if (wb.i_wb_data[CTRL_CLR]) {under_q, over_q} <= '0;
                if (wb.i_wb_data[CTRL_AUXLD]) aux_q <= wb.i_wb_data[CTRL_AUX +: NAUX];
            end
            // Sticky events override a clear issued in the same cycle.
            if (tick && fifo_empty) under_q <= 1'b1;
            if (push && fifo_full) over_q <= 1'b1;
            int_q <= enable_q && (fill <= (LGFIFO+1)'(2 ** (LGFIFO - 1)));
            ack_q <= wb.i_wb_stb;
            if (wb.i_wb_stb) rdata_q <= rdata_d;
        end
    end

    assign ctrl_rd = 32'({aux_q, 14'b0, over_q, under_q, fifo_full, int_q, 1'b0, enable_q});
    assign rdata_d = (wb.i_wb_addr == ADDR_SAMPLE) ? {16'(fill), 16'(duty_q[0])}
                   : (wb.i_wb_addr == ADDR_CTRL)   ? ctrl_rd
                   : (wb.i_wb_addr == ADDR_RELOAD) ? 32'(reload)
                   : {29'b0, wr_chan_q};

    assign wb.o_wb_ack   = ack_q;
    assign wb.o_wb_stall = 1'b0;
    assign wb.o_wb_data  = rdata_q;
    assign o_aux         = aux_q;
    assign o_int         = int_q;
    assign unused_ok     = &{1'b0, wb.i_wb_cyc, wb.i_wb_data, stage_q[FW-1 -: SB]};
endmodule

// File: tb/tb_wbmultipwm.sv
// tb_wbmultipwm: scoreboard bench for wbmultipwm with directed register and PWM vectors
module tb_wbmultipwm;
    typedef struct {
        logic        chk;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] pwm, aux;
    logic       irq;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb_q[$];
    exp_t       got;

    always #5 clk = ~clk;

    wbmultipwm_if bus();
    wbmultipwm dut (.i_clk(clk), .i_reset(rst), .wb(bus), .o_pwm(pwm), .o_aux(aux), .o_int(irq));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: finished=0 required=1");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) if (bus.o_wb_ack) begin
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ack: got ack=1 want no ack");
        end else begin
            got = sb_q.pop_front();
            if (got.chk) begin
                checks++;
                if (bus.o_wb_data !== got.exp) begin
                    errors++;
                    $display("FAIL %s: got %h want %h", got.name, bus.o_wb_data, got.exp);
                end
            end
        end
    end

    task automatic op(input logic we, input logic [1:0] a, input logic [31:0] d,
                      input logic chk, input logic [31:0] exp, input string name);
        exp_t e;
        e.chk = chk;
        e.exp = exp;
        e.name = name;
        sb_q.push_back(e);
        bus.i_wb_cyc = 1'b1;
        bus.i_wb_stb = 1'b1;
        bus.i_wb_we = we;
        bus.i_wb_addr = a;
        bus.i_wb_data = d;
        @(negedge clk);
        bus.i_wb_cyc = 1'b0;
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        op(1'b1, a, d, 1'b0, 32'h0, "write");
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        op(1'b0, a, 32'h0, 1'b1, exp, name);
    endtask

    task automatic frame(input logic [31:0] s0, input logic [31:0] s1);
        wr(2'd0, s0);
        wr(2'd0, s1);
    endtask

    task automatic measure(input int n, input int e0, input int e1, input string name);
        int h0 = 0;
        int h1 = 0;
        repeat (n) begin
            @(negedge clk);
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
        end
        check({name, "_ch0"}, h0, e0);
        check({name, "_ch1"}, h1, e1);
    endtask

    initial begin
        bus.i_wb_cyc = 1'b0;
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we = 1'b0;
        bus.i_wb_addr = 2'd0;
        bus.i_wb_data = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_pwm", int'(pwm), 0);
        check("reset_aux", int'(aux), 0);
        check("reset_int", int'(irq), 0);
        check("reset_ack", int'(bus.o_wb_ack), 0);
        check("stall", int'(bus.o_wb_stall), 0);
        rd(2'd0, 32'h0000_038B, "reset_sample");
        rd(2'd1, 32'h0000_0000, "reset_ctrl");
        rd(2'd2, 32'd1814, "reset_reload");
        rd(2'd3, 32'h0, "reset_chan");

        wr(2'd1, 32'h0021_0000);
        rd(2'd1, 32'h0020_0000, "aux_ctrl");
        check("aux_pins", int'(aux), 2);

        wr(2'd1, 32'h1);
        repeat (2000) @(negedge clk);
        rd(2'd1, 32'h0020_0015, "underflow_ctrl");
        rd(2'd0, 32'h0000_038B, "underflow_duty");

        frame(32'h0, 32'h0);
        repeat (3700) @(negedge clk);
        measure(1814, 907, 907, "mid");

        frame(32'h7FFF, 32'h8000);
        repeat (3700) @(negedge clk);
        measure(1814, 1814, 0, "clamp");
        rd(2'd0, 32'h0000_0716, "clamp_duty");

        wr(2'd1, 32'h0);
        wr(2'd1, 32'h4);
        for (int i = 0; i < 17; i++) frame(32'h0, 32'h0);
        rd(2'd1, 32'h0020_0028, "overflow_ctrl");
        rd(2'd0, 32'h0010_0716, "overflow_fill");
        check("disabled_pwm", int'(pwm), 0);
        wr(2'd1, 32'h4);
        rd(2'd1, 32'h0020_0008, "overflow_clear");

        wr(2'd1, 32'h1);
        rd(2'd1, 32'h0020_0009, "full_no_int");
        wr(2'd1, 32'h3);
        rd(2'd1, 32'h0020_0005, "flush_ctrl");
        rd(2'd0, 32'h0000_0716, "flush_fill");

        wr(2'd0, 32'h11);
        wr(2'd0, 32'h22);
        wr(2'd0, 32'h33);
        rd(2'd3, 32'h1, "stage_chan");
        rd(2'd0, 32'h0001_0716, "stage_fill");
        wr(2'd1, 32'h3);
        rd(2'd3, 32'h0, "flush_chan");
        rd(2'd0, 32'h0000_0716, "flush_fill2");
        frame(32'h64, 32'hFF38);
        repeat (3700) @(negedge clk);
        measure(1814, 1007, 707, "post_flush");
        rd(2'd0, 32'h0000_03EF, "post_flush_duty");
        rd(2'd1, 32'h0020_0015, "post_flush_ctrl");

`ifdef WBMULTIPWM_VARIABLE_RATE_EN
        wr(2'd2, 32'd100);
        rd(2'd2, 32'd100, "reload_100");
        frame(32'd10, 32'hFFFF);
        repeat (2000) @(negedge clk);
        measure(100, 60, 49, "rate100");
        wr(2'd2, 32'd1);
        rd(2'd2, 32'd2, "reload_min");
        frame(32'd10, 32'hFFFF);
        repeat (300) @(negedge clk);
        measure(100, 100, 0, "rate2");
`else
        wr(2'd2, 32'd100);
        rd(2'd2, 32'd1814, "reload_fixed");
`endif

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
